// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice.
//   - state_t : fetch/execute/halt controller state
//   - default address/instruction widths and return-stack depth
package pc_seq_pkg;

    localparam int AW_DEF        = 16;
    localparam int IW_DEF        = 16;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and the instruction memory.
//   imem_req  : fetch request (sequencer -> memory)
//   imem_addr : fetch address (sequencer -> memory)
//   imem_ack  : single-cycle data-valid pulse (memory -> sequencer)
//   imem_data : fetched instruction (memory -> sequencer)
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_data);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack.
//   push/din  : store din on top; when full the oldest entry is overwritten
//   pop       : drop top entry (caller never pops when empty, never pushes and
//               pops in the same cycle)
//   dout      : current top entry, valid when !empty
//   empty/full: occupancy flags; count saturates at DEPTH
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;   // next free slot; top of stack is ptr-1
    logic [CW-1:0] cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign dout  = mem[ptr - PW'(1)];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            // When full, ptr already points at the oldest entry, so the
            // write below recycles it and the count stays saturated.
            ptr <= ptr + PW'(1);
            if (!full) cnt <= cnt + CW'(1);
        end else if (pop) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving an external always-counting 16-bit PC.
//   pc_cur            : current counter value
//   pc_sel/pc_in      : load pc_in on the next edge (also used to hold the PC)
//   pc_dec            : count down instead of up when pc_sel=0
//   imem              : instruction fetch bus (master side)
//   instr             : latched instruction for the external decoder
//   dec_*             : decoder control-flow flags (one-hot or none)
//   stall/resume      : hold EXEC for a cycle / leave HALT
//   halted            : high while in HALT
//   ras_ovf/ras_unf   : sticky return-stack overflow / underflow
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int IW        = IW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [AW-1:0]  pc_cur,
    output logic           pc_sel,
    output logic           pc_dec,
    output logic [AW-1:0]  pc_in,
    pc_sequencer_if.master imem,
    output logic [IW-1:0]  instr,
    input  logic           dec_jump,
    input  logic           dec_call,
    input  logic           dec_ret,
    input  logic           dec_back,
    input  logic           dec_halt,
    input  logic [AW-1:0]  dec_target,
    input  logic           stall,
    input  logic           resume,
    output logic           halted,
    output logic           ras_ovf,
    output logic           ras_unf
);
    state_t        state, nxt;
    logic          req, capture, push, pop, set_ovf, set_unf;
    logic          ras_empty, ras_full;
    logic [AW-1:0] ras_dout;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_cur;

    pc_ras #(.AW(AW), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_cur + AW'(1)),
        .dout  (ras_dout),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            instr   <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state   <= nxt;
            if (capture) instr <= imem.imem_data;
            ras_ovf <= ras_ovf | set_ovf;
            ras_unf <= ras_unf | set_unf;
        end
    end

    // The counter moves on every edge, so the default action is "hold":
    // load the current value back in.
    always_comb begin
        nxt     = state;
        pc_sel  = 1'b1;
        pc_dec  = 1'b0;
        pc_in   = pc_cur;
        req     = 1'b0;
        halted  = 1'b0;
        capture = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (reset) begin
            pc_in = '0;
        end else begin
            unique case (state)
                FETCH: begin
                    req = 1'b1;
                    if (imem.imem_ack) begin
                        capture = 1'b1;
                        nxt     = EXEC;
                    end
                end
                EXEC: begin
                    if (stall) begin
                        nxt = EXEC;
                    end else if (dec_halt) begin
                        pc_sel = 1'b0;
                        nxt    = HALT;
                    end else if (dec_jump) begin
                        pc_in = dec_target;
                        nxt   = FETCH;
                    end else if (dec_call) begin
                        push    = 1'b1;
                        set_ovf = ras_full;
                        pc_in   = dec_target;
                        nxt     = FETCH;
                    end else if (dec_ret) begin
                        if (ras_empty) begin
                            set_unf = 1'b1;
                            nxt     = HALT;
                        end else begin
                            pop   = 1'b1;
                            pc_in = ras_dout;
                            nxt   = FETCH;
                        end
                    end else if (dec_back) begin
                        pc_sel = 1'b0;
                        pc_dec = 1'b1;
                        nxt    = FETCH;
                    end else begin
                        pc_sel = 1'b0;
                        nxt    = FETCH;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                    if (resume) nxt = FETCH;
                end
                default: nxt = FETCH;
            endcase
        end
    end

endmodule
